// File: rtl/gen_sp_reg_mem_pkg.sv
// Shared types for the generic single-port register memory.
// The access decode turns cs/wen into one of three mutually exclusive operations.
package gen_sp_reg_mem_pkg;

   typedef enum logic [1:0] {
      AccIdle,
      AccRead,
      AccWrite
   } acc_e;

   function automatic acc_e decode_acc(input logic cs, input logic wen);
      if (!cs) begin
         return AccIdle;
      end
      return wen ? AccWrite : AccRead;
   endfunction

endpackage

// File: rtl/gen_sp_reg_mem.sv
// Generic single-port flop memory: synchronous write with optional per-bit mask,
// registered read, out-of-range reads return zero and out-of-range writes are dropped.
module gen_sp_reg_mem
   import gen_sp_reg_mem_pkg::*;
#(
   parameter int unsigned DAT_W      = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADD_W      = $clog2(DEPTH),
   parameter bit          BIT_EN_OPT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cs,
   input  logic             wen,
   input  logic [ADD_W-1:0] add,
   input  logic [DAT_W-1:0] dat_in,
   input  logic [DAT_W-1:0] bit_sel,
   output logic [DAT_W-1:0] dat_out
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADD_W still compares correctly.
   localparam int unsigned CMP_W = ADD_W + 1;

   logic [DAT_W-1:0] mem_q [DEPTH];
   logic [DAT_W-1:0] dat_out_q;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic [DAT_W-1:0] wr_word;
   logic [DAT_W-1:0] rd_word;
   acc_e             acc;

   function automatic logic [DAT_W-1:0] merge(input logic [DAT_W-1:0] old_word,
                                              input logic [DAT_W-1:0] new_word,
                                              input logic [DAT_W-1:0] mask);
      if (BIT_EN_OPT) begin
         return (old_word & ~mask) | (new_word & mask);
      end
      return new_word;
   endfunction

   assign acc      = decode_acc(cs, wen);
   assign in_range = {1'b0, add} < CMP_W'(DEPTH);
   // Index is only used when in_range holds, so truncating the upper bits cannot alias.
   assign idx      = IDX_W'(add);

   always_comb begin
      wr_word = merge(mem_q[idx], dat_in, bit_sel);
      rd_word = in_range ? mem_q[idx] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         dat_out_q <= '0;
      end else begin
         case (acc)
            AccWrite: begin
               if (in_range) begin
                  mem_q[idx] <= wr_word;
               end
            end
            AccRead: dat_out_q <= rd_word;
            default: ;
         endcase
      end
   end

   assign dat_out = dat_out_q;

endmodule

// File: tb/tb_gen_sp_reg_mem.sv
// Randomized bench for gen_sp_reg_mem: two configurations driven in lockstep and
// compared every cycle against array-based reference models.
module tb_gen_sp_reg_mem;

   logic        clk;
   logic        rst_n;
   logic        cs;
   logic        wen;
   logic [29:0] add;
   logic [31:0] dat_in;
   logic [31:0] bit_sel;

   // Config A: 8-bit masked memory, 8 words, 30-bit address.
   logic [7:0]  dout_a;
   // Config B: 32-bit unmasked memory, 256 words, 8-bit address.
   logic [7:0]  add_b;
   logic [31:0] dout_b;

   int n_checks;
   int n_fail;

   logic [7:0]  ref_a [8];
   logic [7:0]  exp_a;
   logic [31:0] ref_b [256];
   logic [31:0] exp_b;

   assign add_b = add[7:0];

   gen_sp_reg_mem #(
      .DAT_W     (8),
      .DEPTH     (8),
      .ADD_W     (30),
      .BIT_EN_OPT(1'b1)
   ) u_dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .cs     (cs),
      .wen    (wen),
      .add    (add),
      .dat_in (dat_in[7:0]),
      .bit_sel(bit_sel[7:0]),
      .dat_out(dout_a)
   );

   gen_sp_reg_mem #(
      .DAT_W     (32),
      .DEPTH     (256),
      .ADD_W     (8),
      .BIT_EN_OPT(1'b0)
   ) u_dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .cs     (cs),
      .wen    (wen),
      .add    (add_b),
      .dat_in (dat_in),
      .bit_sel(bit_sel),
      .dat_out(dout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) ref_a[i] = 8'h00;
      for (int i = 0; i < 256; i++) ref_b[i] = 32'h0;
      exp_a = 8'h00;
      exp_b = 32'h0;
   endtask

   // Applies one access, lets the edge happen, updates the models, then checks both outputs.
   task automatic step(input logic c, input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [31:0] bs, input string tag);
      cs      = c;
      wen     = w;
      add     = a;
      dat_in  = d;
      bit_sel = bs;
      @(posedge clk);
      if (c && w) begin
         if (a < 30'd8) ref_a[a] = (ref_a[a] & ~bs[7:0]) | (d[7:0] & bs[7:0]);
         ref_b[a[7:0]] = d;
      end else if (c) begin
         exp_a = (a < 30'd8) ? ref_a[a] : 8'h00;
         exp_b = ref_b[a[7:0]];
      end
      #1;
      check_val({tag, "_a"}, {24'h0, dout_a}, {24'h0, exp_a});
      check_val({tag, "_b"}, dout_b, exp_b);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cs       = 1'b0;
      wen      = 1'b0;
      add      = '0;
      dat_in   = '0;
      bit_sel  = '0;
      rst_n    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_a", {24'h0, dout_a}, 32'h0);
      check_val("reset_b", dout_b, 32'h0);
      rst_n = 1'b1;

      // Reset mid-operation clears storage and output asynchronously.
      step(1, 1, 30'd2, 32'h0000_00A5, 32'hFF, "rst_wr");
      step(1, 0, 30'd2, 32'h0, 32'h0, "rst_rd");
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_val("async_clr_a", {24'h0, dout_a}, 32'h0);
      check_val("async_clr_b", dout_b, 32'h0);
      #2 rst_n = 1'b1;
      step(1, 0, 30'd2, 32'h0, 32'h0, "post_rst_rd");

      // Full-word write/read including the top address of config B.
      step(1, 1, 30'd5,   32'hDEAD_BEEF, 32'hFF, "wr5");
      step(1, 1, 30'd255, 32'h1234_5678, 32'hFF, "wr255");
      step(1, 0, 30'd5,   32'h0, 32'h0, "rd5");
      step(1, 0, 30'd255, 32'h0, 32'h0, "rd255");

      // Bit mask: config A keeps the upper nibble, config B takes the whole word.
      step(1, 1, 30'd1, 32'hFF, 32'hFF, "mask_wr1");
      step(1, 1, 30'd1, 32'h00, 32'h0F, "mask_wr2");
      step(1, 0, 30'd1, 32'h0, 32'h0, "mask_rd");
      check_val("mask_val", {24'h0, dout_a}, 32'hF0);

      // cs gating: dat_out and storage hold while deselected.
      step(1, 1, 30'd3, 32'h11, 32'hFF, "cs_wr");
      step(1, 0, 30'd3, 32'h0, 32'h0, "cs_rd");
      for (int i = 0; i < 3; i++) step(0, 1, 30'd3, 32'h22, 32'hFF, "cs_idle");
      step(1, 0, 30'd3, 32'h0, 32'h0, "cs_rd2");
      check_val("cs_val", {24'h0, dout_a}, 32'h11);

      // Out of range on config A: no write, read returns 0, no aliasing onto word 0.
      step(1, 1, 30'd0, 32'h5A, 32'hFF, "oor_pre");
      step(1, 1, 30'd8, 32'h77, 32'hFF, "oor_wr");
      step(1, 0, 30'd8, 32'h0, 32'h0, "oor_rd8");
      step(1, 0, 30'd0, 32'h0, 32'h0, "oor_rd0");
      step(1, 1, 30'h2000_0000, 32'h66, 32'hFF, "oor_hi_wr");
      step(1, 0, 30'd0, 32'h0, 32'h0, "oor_hi_rd0");

      // Back-to-back write then read.
      step(1, 1, 30'd4, 32'h3C, 32'hFF, "b2b_wr");
      step(1, 0, 30'd4, 32'h0, 32'h0, "b2b_rd");
      check_val("b2b_val", {24'h0, dout_a}, 32'h3C);

      for (int i = 0; i < 400; i++) begin
         logic        c;
         logic        w;
         logic [29:0] a;
         c = ($urandom_range(0, 3) != 0);
         w = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 7))
            0:       a = 30'($urandom);
            1:       a = 30'(256 + $urandom_range(0, 7));
            default: a = 30'($urandom_range(0, 11));
         endcase
         step(c, w, a, $urandom, $urandom, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
